ip_in_ctrl: RTL
===============

IP_IN_CTRL -- requirements
Module: ip_in_ctrl

Interface
REQ-001 SHALL have parameter DB_CNT, default 50000, debounce settle cycles (1 ms at 50 MHz); legal range 2..2**20-1.
REQ-002 SHALL have parameter SW_W, default 32, switch bus width.
REQ-003 SHALL have parameter BTN_W, default 4, button bus width.
REQ-004 SHALL have the following ports, and only these:
  i_clk  in  1  single clock, rising edge
  i_rst  in  1  asynchronous active-low reset
  i_io_sw  in  SW_W  raw switch inputs, asynchronous
  i_io_btn  in  BTN_W  raw button inputs, asynchronous
  i_lsu_addr  in  32  LSU byte address
  i_lsu_wren  in  1  LSU store strobe, one cycle per store
  i_st_data  in  32  LSU store data
  o_ip_data  out  32  read data, combinational from i_lsu_addr
  o_irq  out  1  level interrupt request

Function
REQ-005 SHALL pass each raw input bus through a 2-flop synchronizer before any other use.
REQ-006 SHALL debounce each bus with one FSM per bus, states IDLE, COUNT, COMMIT; 20-bit counter; candidate register; stable register.
REQ-007 IDLE: if synced != stable -> COUNT, candidate <= synced, cnt <= 0.
REQ-008 COUNT: synced == stable -> IDLE; synced != candidate -> candidate <= synced, cnt <= 0; cnt == DB_CNT-1 -> COMMIT; otherwise cnt <= cnt+1.
REQ-009 COMMIT: stable <= candidate; then -> IDLE, unconditionally, in one cycle.
REQ-010 Latency: with an input changed and held from sampling edge t0, the new stable value SHALL be readable after edge t0+DB_CNT+3, no earlier.
REQ-011 Button COMMIT SHALL set edge[i] for each bit with stable 0 -> candidate 1; falling edges set nothing.
REQ-012 Register map, decoded on full i_lsu_addr, word-aligned:
  0x7800 SW  RO  stable switches, zero-extended
  0x7810 BTN  RO  stable buttons, zero-extended
  0x7814 EDGE  W1C  latched rising-edge flags
  0x7818 IRQEN  RW  bit 0 enables o_irq; other bits read 0
REQ-013 Any unmapped address SHALL read 32'h0.
REQ-014 Stores to RO or unmapped addresses SHALL be ignored.
REQ-015 A store to EDGE SHALL clear bit i where i_st_data[i] = 1.
REQ-016 A set and a clear of the same EDGE bit in the same cycle SHALL leave the bit set.
REQ-017 o_irq SHALL be registered: o_irq <= IRQEN[0] & |EDGE, one cycle behind the register state.

Reset
REQ-018 i_rst low SHALL asynchronously clear synchronizers, counters, candidate, stable, EDGE, IRQEN and o_irq, and force both FSMs to IDLE.
REQ-019 A reset during COUNT SHALL discard the debounce in progress; a held input restarts from IDLE after release and is not marked as an edge unless it is a button at 1.
REQ-020 o_ip_data SHALL read 32'h0 at mapped addresses during reset.

Configuration
REQ-021 Macro IP_IN_CTRL_IRQ_EN: when defined, IRQEN and o_irq SHALL behave as in REQ-012 and REQ-017.
REQ-022 When IP_IN_CTRL_IRQ_EN is not defined: IRQEN SHALL read 0 and ignore writes; o_irq SHALL be tied 0; EDGE SHALL be unaffected.

Structure
REQ-023 Shared package ip_pkg SHALL hold the address constants IP_SW_ADDR, IP_BTN_ADDR, IP_EDGE_ADDR and IP_IRQEN_ADDR, plus the FSM enum db_state_e {IDLE, COUNT, COMMIT}.
REQ-024 The synchronizer, FSM, counter and candidate/stable registers SHALL be a sub-module ip_debounce (params W, DB_CNT), instanced once for switches and once for buttons.
REQ-025 ip_debounce SHALL output a one-cycle commit pulse plus the stable and previous-stable values.

Verification (DB_CNT=4)
REQ-026 sw 0 -> 32'hA5A5_0001 at edge t0, held: SW reads 0 through edge t0+DB_CNT+2 and reads 32'hA5A5_0001 after edge t0+DB_CNT+3.
REQ-027 btn[2] pulsed 0 -> 1 for 2 cycles, then 0: BTN stays 0 and EDGE stays 0.
REQ-028 btn = 4'b0101 held: EDGE = 0x5; store 0x1 to 0x7814 -> EDGE = 0x4; store 0x4 in the same cycle btn[2] commits a new rise -> EDGE bit 2 stays 1.
REQ-029 IRQEN = 1 and EDGE goes 0 -> 0x1: o_irq rises one cycle later; with IRQEN = 0, o_irq stays 0; without the macro, o_irq = 0 always.
REQ-030 i_rst asserted mid-COUNT with sw held at 32'hFF: outputs clear immediately; after release, SW = 32'hFF at DB_CNT+3 edges after the first post-reset sampling edge.
REQ-031 Read 0x7804, 0x781C and 0x8000 -> 32'h0; store to 0x7800 -> SW unchanged.

Source files
------------

// File: rtl/ip_in_ctrl_pkg.sv
// Shared constants for the input controller: register addresses and the
// debounce FSM state type.
package ip_pkg;

  localparam logic [31:0] IP_SW_ADDR    = 32'h0000_7800;
  localparam logic [31:0] IP_BTN_ADDR   = 32'h0000_7810;
  localparam logic [31:0] IP_EDGE_ADDR  = 32'h0000_7814;
  localparam logic [31:0] IP_IRQEN_ADDR = 32'h0000_7818;

  localparam int unsigned DB_CNT_W = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } db_state_e;

endpackage

// File: rtl/ip_in_ctrl_if.sv
// Signal bundle for the input controller's LSU and raw-input side, letting an
// environment connect to the flat ports of ip_in_ctrl through modports.
interface ip_in_ctrl_if #(
  parameter int unsigned SW_W  = 32,
  parameter int unsigned BTN_W = 4
) ();

  logic [SW_W-1:0]  io_sw;
  logic [BTN_W-1:0] io_btn;
  logic [31:0]      lsu_addr;
  logic             lsu_wren;
  logic [31:0]      st_data;
  logic [31:0]      ip_data;
  logic             irq;

  modport master (
    output io_sw, io_btn, lsu_addr, lsu_wren, st_data,
    input  ip_data, irq
  );

  modport slave (
    input  io_sw, io_btn, lsu_addr, lsu_wren, st_data,
    output ip_data, irq
  );

endinterface

// File: rtl/ip_in_ctrl_debounce.sv
// Two-flop synchronizer plus settle-count debounce for a W-bit bus; emits a
// one-cycle commit pulse together with the new and previous stable values.
module ip_debounce
  import ip_pkg::*;
#(
  parameter int unsigned W      = 1,
  parameter int unsigned DB_CNT = 50000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] raw_i,
  output logic         commit_o,
  output logic [W-1:0] stable_o,
  output logic [W-1:0] prev_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CNT - 1);

  logic [W-1:0]          sync1_q, sync2_q;
  logic [W-1:0]          cand_q, cand_d;
  logic [W-1:0]          stable_q, stable_d;
  logic [W-1:0]          prev_q, prev_d;
  logic [DB_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  commit_q, commit_d;
  db_state_e             state_q, state_d;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    prev_d   = prev_q;
    commit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != stable_q) begin
          state_d = COUNT;
          cand_d  = sync2_q;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (sync2_q == stable_q) begin
          state_d = IDLE;
        end else if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        // Input is ignored here; the pulse is registered so prev/stable line up with it.
        stable_d = cand_q;
        prev_d   = stable_q;
        commit_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      state_q  <= IDLE;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      state_q  <= state_d;
    end
  end

  assign commit_o = commit_q;
  assign stable_o = stable_q;
  assign prev_o   = prev_q;

endmodule

// File: rtl/ip_in_ctrl.sv
// Debounced switch/button input block with LSU register map and rising-edge
// interrupt. Define IP_IN_CTRL_IRQ_EN to build the IRQEN register and o_irq.
module ip_in_ctrl
  import ip_pkg::*;
#(
  parameter int unsigned DB_CNT = 50000,
  parameter int unsigned SW_W   = 32,
  parameter int unsigned BTN_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [BTN_W-1:0] i_io_btn,
  input  logic [31:0]      i_lsu_addr,
  input  logic             i_lsu_wren,
  input  logic [31:0]      i_st_data,
  output logic [31:0]      o_ip_data,
  output logic             o_irq
);

  logic             sw_commit;
  logic [SW_W-1:0]  sw_stable, sw_prev;
  logic             btn_commit;
  logic [BTN_W-1:0] btn_stable, btn_prev;

  ip_debounce #(.W(SW_W), .DB_CNT(DB_CNT)) u_sw_db (
    .clk_i    (i_clk),
    .rst_ni   (i_rst),
    .raw_i    (i_io_sw),
    .commit_o (sw_commit),
    .stable_o (sw_stable),
    .prev_o   (sw_prev)
  );

  ip_debounce #(.W(BTN_W), .DB_CNT(DB_CNT)) u_btn_db (
    .clk_i    (i_clk),
    .rst_ni   (i_rst),
    .raw_i    (i_io_btn),
    .commit_o (btn_commit),
    .stable_o (btn_stable),
    .prev_o   (btn_prev)
  );

  logic [BTN_W-1:0] edge_q, edge_d, edge_set, edge_clr;
  logic             irqen_q;
  logic             irq_q;
  logic             wr_edge;

  assign wr_edge  = i_lsu_wren && (i_lsu_addr == IP_EDGE_ADDR);
  assign edge_set = btn_commit ? (btn_stable & ~btn_prev) : '0;
  assign edge_clr = wr_edge ? i_st_data[BTN_W-1:0] : '0;
  // Set wins over a same-cycle W1C clear of the same bit.
  assign edge_d   = (edge_q & ~edge_clr) | edge_set;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

`ifdef IP_IN_CTRL_IRQ_EN
  logic irqen_d, irq_d;

  assign irqen_d = (i_lsu_wren && (i_lsu_addr == IP_IRQEN_ADDR)) ? i_st_data[0] : irqen_q;
  assign irq_d   = irqen_q & (|edge_q);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
    end
  end
`else
  assign irqen_q = 1'b0;
  assign irq_q   = 1'b0;
`endif

  assign o_irq = irq_q;

  always_comb begin
    o_ip_data = '0;
    case (i_lsu_addr)
      IP_SW_ADDR:    o_ip_data = 32'(sw_stable);
      IP_BTN_ADDR:   o_ip_data = 32'(btn_stable);
      IP_EDGE_ADDR:  o_ip_data = 32'(edge_q);
      IP_IRQEN_ADDR: o_ip_data = {31'b0, irqen_q};
      default:       o_ip_data = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{i_st_data[31:BTN_W], sw_commit, sw_prev};

endmodule
